// File: rtl/core_pkg.sv
// Core-wide widths and memory-control encodings shared by the pipeline stages.
// Bit 3 of a memory-control code marks a store; MEM_IDLE marks a non-memory uop.
package core_pkg;

   localparam int DATA_WIDTH        = 32;
   localparam int ADDR_OFFSET_WIDTH = $clog2(DATA_WIDTH / 8);
   localparam int MEM_CTRL_WIDTH    = 4;

   localparam logic [MEM_CTRL_WIDTH-1:0] MEM_IDLE = 4'b0000;
   localparam logic [MEM_CTRL_WIDTH-1:0] MEM_RB   = 4'b0001;
   localparam logic [MEM_CTRL_WIDTH-1:0] MEM_RH   = 4'b0010;
   localparam logic [MEM_CTRL_WIDTH-1:0] MEM_RW   = 4'b0011;
   localparam logic [MEM_CTRL_WIDTH-1:0] MEM_RD   = 4'b0100;
   localparam logic [MEM_CTRL_WIDTH-1:0] MEM_RBU  = 4'b0101;
   localparam logic [MEM_CTRL_WIDTH-1:0] MEM_RHU  = 4'b0110;
   localparam logic [MEM_CTRL_WIDTH-1:0] MEM_RWU  = 4'b0111;
   localparam logic [MEM_CTRL_WIDTH-1:0] MEM_WB   = 4'b1000;
   localparam logic [MEM_CTRL_WIDTH-1:0] MEM_WH   = 4'b1001;
   localparam logic [MEM_CTRL_WIDTH-1:0] MEM_WW   = 4'b1010;
   localparam logic [MEM_CTRL_WIDTH-1:0] MEM_WD   = 4'b1011;

   function automatic logic is_load(input logic [MEM_CTRL_WIDTH-1:0] ctrl);
      return (ctrl != MEM_IDLE) && !ctrl[3];
   endfunction

endpackage

// File: rtl/load_aligner.sv
// Combinational load data alignment: shifts the aligned word down by the byte
// offset, then truncates and sign/zero extends according to the access size.
module load_aligner
   import core_pkg::*;
(
   input  logic [MEM_CTRL_WIDTH-1:0]    mem_ctrl,
   input  logic [ADDR_OFFSET_WIDTH-1:0] offset,
   input  logic [DATA_WIDTH-1:0]        rdata,
   output logic [DATA_WIDTH-1:0]        data
);

   logic [DATA_WIDTH-1:0] shifted;

   // Bytes shifted in above a word-crossing access are simply zeros.
   assign shifted = rdata >> {offset, 3'b000};

   generate
      if (DATA_WIDTH == 64) begin : gen_64
         always_comb begin
            data = shifted;
            case (mem_ctrl)
               MEM_RB:  data = DATA_WIDTH'($signed(shifted[7:0]));
               MEM_RBU: data = DATA_WIDTH'(shifted[7:0]);
               MEM_RH:  data = DATA_WIDTH'($signed(shifted[15:0]));
               MEM_RHU: data = DATA_WIDTH'(shifted[15:0]);
               MEM_RW:  data = DATA_WIDTH'($signed(shifted[31:0]));
               MEM_RWU: data = DATA_WIDTH'(shifted[31:0]);
               default: data = shifted;
            endcase
         end
      end else begin : gen_32
         always_comb begin
            data = shifted;
            case (mem_ctrl)
               MEM_RB:  data = DATA_WIDTH'($signed(shifted[7:0]));
               MEM_RBU: data = DATA_WIDTH'(shifted[7:0]);
               MEM_RH:  data = DATA_WIDTH'($signed(shifted[15:0]));
               MEM_RHU: data = DATA_WIDTH'(shifted[15:0]);
               default: data = shifted;
            endcase
         end
      end
   endgenerate

endmodule

// File: rtl/wb_unit.sv
// Write-back stage: one-entry register holding the retiring uop, driving the
// register-file write port, the bypass network and the retired-uop counter.
module wb_unit
   import core_pkg::*;
(
   input  logic                      clk_i,
   input  logic                      rst_i,
   input  logic                      mem_valid_i,
   output logic                      ready_o,
   input  logic [MEM_CTRL_WIDTH-1:0] mem_ctrl_i,
   input  logic [DATA_WIDTH-1:0]     exe_out_i,
   input  logic [DATA_WIDTH-1:0]     d_m_rdata_i,
   input  logic [4:0]                rd_addr_i,
   input  logic                      rd_wren_i,
   input  logic                      stall_i,
   output logic                      rf_wren_o,
   output logic [4:0]                rf_waddr_o,
   output logic [DATA_WIDTH-1:0]     rf_wdata_o,
   output logic                      fwd_valid_o,
   output logic [4:0]                fwd_addr_o,
   output logic [DATA_WIDTH-1:0]     fwd_data_o,
   output logic [63:0]               instret_o
);

   logic                  vld_p1;
   logic [4:0]            rd_p1;
   logic                  wren_p1;
   logic [DATA_WIDTH-1:0] result_p1;
   logic [63:0]           instret_q;

   logic                  accept;
   logic                  retire;
   logic [DATA_WIDTH-1:0] load_data;
   logic [DATA_WIDTH-1:0] result_p0;
   logic                  wren_p0;

   load_aligner u_load_aligner (
      .mem_ctrl (mem_ctrl_i),
      .offset   (exe_out_i[ADDR_OFFSET_WIDTH-1:0]),
      .rdata    (d_m_rdata_i),
      .data     (load_data)
   );

   assign ready_o = !rst_i && (!vld_p1 || !stall_i);
   assign accept  = mem_valid_i && ready_o;
   assign retire  = vld_p1 && !stall_i;

   assign result_p0 = is_load(mem_ctrl_i) ? load_data : exe_out_i;
   assign wren_p0   = rd_wren_i && !mem_ctrl_i[3];

   // ---- p0 -> p1 stage boundary ----
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         vld_p1    <= 1'b0;
         rd_p1     <= '0;
         wren_p1   <= 1'b0;
         result_p1 <= '0;
         instret_q <= '0;
      end else begin
         if (retire)
            instret_q <= instret_q + 64'd1;
         if (accept) begin
            vld_p1    <= 1'b1;
            rd_p1     <= rd_addr_i;
            wren_p1   <= wren_p0;
            result_p1 <= result_p0;
         end else if (retire) begin
            vld_p1    <= 1'b0;
         end
      end
   end

   assign fwd_valid_o = !rst_i && vld_p1 && wren_p1 && (rd_p1 != 5'd0);
   assign fwd_addr_o  = vld_p1 ? rd_p1 : 5'd0;
   assign fwd_data_o  = vld_p1 ? result_p1 : '0;

   assign rf_wren_o   = fwd_valid_o && !stall_i;
   assign rf_waddr_o  = vld_p1 ? rd_p1 : 5'd0;
   assign rf_wdata_o  = vld_p1 ? result_p1 : '0;

   assign instret_o   = instret_q;

endmodule
